// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD search controller slice.
package sad_pkg;
    localparam int PIX_W    = 8;
    localparam int BLK_DIM  = 16;
    localparam int ROW_BITS = 128;
    localparam int BLK_BITS = 2048;
    localparam int SAD_W    = 16;

    localparam logic [SAD_W-1:0] SAD_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_REF,
        CAL,
        WAIT,
        DONE
    } state_t;
endpackage

// File: rtl/sad_search_ctrl_if.sv
// Pixel stream and SAD engine bus of the search controller; master is the controller side.
interface sad_search_ctrl_if;
    import sad_pkg::*;

    logic [ROW_BITS-1:0] pix_data;
    logic                pix_valid;
    logic                pix_ready;
    logic [BLK_BITS-1:0] din;
    logic [BLK_BITS-1:0] refi;
    logic                cal_en;
    logic [SAD_W-1:0]    sad;
    logic                sad_val;

    modport master (
        input  pix_data, pix_valid, sad, sad_val,
        output pix_ready, din, refi, cal_en
    );

    modport slave (
        output pix_data, pix_valid, sad, sad_val,
        input  pix_ready, din, refi, cal_en
    );
endinterface

// File: rtl/sad_blk_pack.sv
// Packs 16 accepted row beats into a 2048-bit block; row r lands at blk[128r+:128].
module sad_blk_pack
    import sad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] row_data,
    output logic [BLK_BITS-1:0] blk,
    output logic                last_row
);

    logic [3:0] row_cnt;

    // The 4-bit counter wraps 15 -> 0, so it is realigned at every block end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            blk     <= '0;
        end else if (wr_en) begin
            blk[{row_cnt, 7'b0} +: ROW_BITS] <= row_data;
            row_cnt                          <= row_cnt + 4'd1;
        end
    end

    assign last_row = (row_cnt == 4'd15);

endmodule

// File: rtl/sad_search_ctrl.sv
// SAD search controller: loads a current block and NUM_CAND candidates, tracks the minimum SAD.
// Optional watchdog on the SAD result enabled by SAD_SEARCH_TIMEOUT_EN.
module sad_search_ctrl
    import sad_pkg::*;
#(
    parameter int NUM_CAND = 8
`ifdef SAD_SEARCH_TIMEOUT_EN
    ,
    parameter int TMO_CYC  = 64
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    sad_search_ctrl_if.master   sif,
    output logic [SAD_W-1:0]    best_sad,
    output logic [7:0]          best_idx,
    output logic                done,
    output logic                busy
`ifdef SAD_SEARCH_TIMEOUT_EN
    ,
    output logic                tmo_err
`endif
);

    state_t           state, state_nxt;
    logic [7:0]       cand_cnt;
    logic             cur_we, ref_we, cur_last, ref_last;
    logic             sad_hit, last_cand;
    logic [SAD_W-1:0] sad_eff;

    assign last_cand = (cand_cnt == 8'(NUM_CAND - 1));

`ifdef SAD_SEARCH_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_expired;

    // A missing result is replaced by SAD_MAX, which strict less-than never selects.
    assign wd_expired = (state == WAIT) && !sif.sad_val && (wd_cnt == 16'(TMO_CYC - 1));
    assign sad_hit    = sif.sad_val || wd_expired;
    assign sad_eff    = sif.sad_val ? sif.sad : SAD_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            tmo_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 16'd1 : 16'd0;
            if (state == IDLE && start)
                tmo_err <= 1'b0;
            else if (wd_expired)
                tmo_err <= 1'b1;
        end
    end
`else
    assign sad_hit = sif.sad_val;
    assign sad_eff = sif.sad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        sif.pix_ready = 1'b0;
        sif.cal_en    = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        cur_we        = 1'b0;
        ref_we        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = LOAD_CUR;
            end
            LOAD_CUR: begin
                sif.pix_ready = 1'b1;
                cur_we        = sif.pix_valid;
                if (sif.pix_valid && cur_last)
                    state_nxt = LOAD_REF;
            end
            LOAD_REF: begin
                sif.pix_ready = 1'b1;
                ref_we        = sif.pix_valid;
                if (sif.pix_valid && ref_last)
                    state_nxt = CAL;
            end
            CAL: begin
                sif.cal_en = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (sad_hit)
                    state_nxt = last_cand ? DONE : LOAD_REF;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are cleared on start rather than in IDLE so they survive until the next search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_cnt <= '0;
            best_sad <= SAD_MAX;
            best_idx <= '0;
        end else if (state == IDLE && start) begin
            cand_cnt <= '0;
            best_sad <= SAD_MAX;
            best_idx <= '0;
        end else if (state == WAIT && sad_hit) begin
            if (sad_eff < best_sad) begin
                best_sad <= sad_eff;
                best_idx <= cand_cnt;
            end
            if (!last_cand)
                cand_cnt <= cand_cnt + 8'd1;
        end
    end

    sad_blk_pack u_cur_pack (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cur_we),
        .row_data (sif.pix_data),
        .blk      (sif.din),
        .last_row (cur_last)
    );

    sad_blk_pack u_ref_pack (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (ref_we),
        .row_data (sif.pix_data),
        .blk      (sif.refi),
        .last_row (ref_last)
    );

endmodule
